// File: rtl/sample_streamer_if.sv
// rtl/sample_streamer_if.sv - sample FIFO pop side and transmitter byte stream bundle
interface sample_streamer_if;
    logic        i_fifo_empty;
    logic        o_fifo_rd;
    logic [31:0] i_fifo_q;
    logic        o_tx_valid;
    logic [7:0]  o_tx_byte;
    logic        i_tx_ready;

    // streamer side
    modport master (
        input  i_fifo_empty,
        input  i_fifo_q,
        input  i_tx_ready,
        output o_fifo_rd,
        output o_tx_valid,
        output o_tx_byte
    );

    // FIFO / transmitter side
    modport slave (
        output i_fifo_empty,
        output i_fifo_q,
        output i_tx_ready,
        input  o_fifo_rd,
        input  o_tx_valid,
        input  o_tx_byte
    );
endinterface

// File: rtl/sample_streamer.sv
// rtl/sample_streamer.sv - pops 32-bit sample records and serializes them LSB byte first (STREAMER_CHECKSUM_EN adds an xor byte)
module sample_streamer #(
    parameter int FIFO_READ_LATENCY = 1
) (
    input  logic                      i_clk,
    input  logic                      _mrst,
    input  logic                      i_enable,
    sample_streamer_if.master         bus,
    output logic                      o_busy,
    output logic [31:0]               o_record_count
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_POP  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
`ifdef STREAMER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM = 3'd4;
`endif

    // WAIT ends on the cycle the FIFO data is valid
    localparam logic LAST_WAIT = (FIFO_READ_LATENCY == 2);

    logic [2:0]  state_q, state_d;
    logic        wait_q, wait_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] rec_q, rec_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic [31:0] count_q, count_d;
    logic        rec_done;
    logic [1:0]  idx_inc;

    assign idx_inc        = idx_q + 2'd1;
    assign bus.o_fifo_rd  = (state_q == S_POP);
    assign bus.o_tx_valid = valid_q;
    assign bus.o_tx_byte  = byte_q;
    assign o_busy         = busy_q;
    assign o_record_count = count_q;

    // next-state: pop, wait for read data, then hand out bytes on each accepted transfer
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        idx_d    = idx_q;
        rec_d    = rec_q;
        byte_d   = byte_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        count_d  = count_q;
        rec_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_enable && !bus.i_fifo_empty) begin
                    state_d = S_POP;
                    busy_d  = 1'b1;
                end
            end
            S_POP: begin
                state_d = S_WAIT;
                wait_d  = 1'b0;
            end
            S_WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    rec_d   = bus.i_fifo_q;
                    byte_d  = bus.i_fifo_q[7:0];
                    valid_d = 1'b1;
                    idx_d   = 2'd0;
                    state_d = S_SEND;
                end else begin
                    wait_d = 1'b1;
                end
            end
            S_SEND: begin
                if (bus.i_tx_ready) begin
                    if (idx_q == 2'd3) begin
`ifdef STREAMER_CHECKSUM_EN
                        byte_d  = rec_q[7:0] ^ rec_q[15:8] ^ rec_q[23:16] ^ rec_q[31:24];
                        state_d = S_CSUM;
`else
                        rec_done = 1'b1;
`endif
                    end else begin
                        idx_d  = idx_inc;
                        byte_d = rec_q[{idx_inc, 3'b000} +: 8];
                    end
                end
            end
`ifdef STREAMER_CHECKSUM_EN
            S_CSUM: begin
                if (bus.i_tx_ready) begin
                    rec_done = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // last byte of the record accepted: close it out and go idle
        if (rec_done) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            byte_d  = 8'h00;
            idx_d   = 2'd0;
            busy_d  = 1'b0;
            count_d = count_q + 32'd1;
        end
    end

    // state registers; reset drops any partially sent record
    always_ff @(posedge i_clk or negedge _mrst) begin
        if (!_mrst) begin
            state_q <= S_IDLE;
            wait_q  <= 1'b0;
            idx_q   <= 2'd0;
            rec_q   <= 32'd0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            rec_q   <= rec_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end
endmodule

// File: doc/sample_streamer.md
Name: sample_streamer

Overview:
- Drain side of the sample FIFO written by the channel capture path (words = {time[23:0], channels[7:0]}).
- Pops one 32-bit record at a time and serializes it LSB-byte-first onto a byte valid/ready interface feeding the host UART transmitter.
- Counts records sent and reports busy/idle so the host-side controller knows when a capture has been fully uploaded.

Parameters:
- FIFO_READ_LATENCY, 1, cycles from o_fifo_rd high to i_fifo_q valid; legal values 1 or 2.

Ports:
- i_clk  input  1  system clock, all logic on rising edge
- _mrst  input  1  asynchronous active-low master reset
- i_enable  input  1  allow starting new records; low = finish current record, then halt
- i_fifo_empty  input  1  sample FIFO empty flag
- o_fifo_rd  output  1  one-cycle pop strobe to sample FIFO
- i_fifo_q  input  32  FIFO read data, {time[23:0], ch[7:0]}
- o_tx_valid  output  1  byte available for transmitter
- o_tx_byte  output  8  byte to transmit
- i_tx_ready  input  1  transmitter accepts byte this cycle
- o_busy  output  1  high from pop until last byte of record accepted
- o_record_count  output  32  records fully transmitted since reset

Behaviour:
- Reset (_mrst low, asynchronous): state IDLE; o_fifo_rd=0, o_tx_valid=0, o_tx_byte=0, o_busy=0, o_record_count=0, byte index=0. Reset mid-record aborts immediately; partial record is lost; no pop is issued on release until the IDLE conditions hold.
- States: IDLE, POP, WAIT, SEND, (CSUM with feature).
- IDLE: if i_enable & ~i_fifo_empty -> POP. Else stay.
- POP: o_fifo_rd=1 for exactly one cycle; o_busy=1 from here. -> WAIT.
- WAIT: count FIFO_READ_LATENCY-1 extra cycles (0 for latency 1); on the cycle i_fifo_q is valid, latch it into the 32-bit record register and load byte 0 into o_tx_byte, set o_tx_valid=1 -> SEND.
- SEND: transfer occurs on a rising edge with o_tx_valid & i_tx_ready. o_tx_byte and o_tx_valid stay stable while i_tx_ready=0. After transfer of byte k (k<3), the next cycle presents byte k+1, so o_tx_valid does not drop between bytes (back-to-back transfers allowed when i_tx_ready is held high, 1 byte/cycle).
- Byte order: byte0=rec[7:0] (channels), byte1=rec[15:8], byte2=rec[23:16], byte3=rec[31:24] (time LSB..MSB).
- After byte3 transfer (or checksum byte if enabled): o_tx_valid=0, o_record_count+=1 (wraps 0xFFFFFFFF->0), o_busy=0, -> IDLE. Minimum gap between records: IDLE->POP, i.e. at least 2 cycles with o_tx_valid=0.
- i_enable falling during POP/WAIT/SEND has no effect on the current record; it only blocks the next IDLE->POP.
- i_fifo_empty is sampled only in IDLE; never pop when empty. i_fifo_empty rising after the pop is ignored.
- i_tx_ready while o_tx_valid=0 is ignored.

Optional Feature:
- Macro STREAMER_CHECKSUM_EN.
- Defined: after byte3, state CSUM presents a fifth byte = byte0 ^ byte1 ^ byte2 ^ byte3 under the same valid/ready rules; the record count increments and the block returns to IDLE only after the checksum byte is accepted.
- Not defined: the CSUM state and checksum logic are absent; the record ends after byte3.

Test Plan:
- Reset: hold _mrst low with i_fifo_empty=0, i_enable=1 -> all outputs 0; deassert -> o_fifo_rd pulses 1 cycle, the next cycle after latency has o_tx_valid=1.
- Single record, ready always 1: FIFO word 0x12345678 -> bytes 0x78,0x56,0x34,0x12 on 4 consecutive cycles; o_record_count=1; o_busy low after the last byte; checksum variant adds 0x08.
- Backpressure: i_tx_ready toggled 0/0/1 per byte on 0xA5A5A5A5 -> each byte held stable while ready=0, exactly 4 transfers, no duplicates or skips.
- Empty/enable gating: i_fifo_empty=1 or i_enable=0 -> o_fifo_rd never asserts; drop i_enable mid-SEND -> current record completes, no further pop.
- Latency 2 with 3 queued words 0x00000001, 0x00000102, 0xFFFFFFFF -> 12 bytes in order 01 00 00 00 02 01 00 00 FF FF FF FF; count=3; exactly 3 pops.
- Reset mid-SEND after byte1 -> o_tx_valid=0 immediately, count stays 0, the next record after release starts at byte0.
